// File: rtl/lsu_bus_ctrl_if.sv
// Data-memory bus between the load/store controller (master) and memory (slave).
`timescale 1ns/1ps
interface lsu_bus_ctrl_if #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned NB   = XLEN / 8
);
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_req_wr;
   logic [XLEN-1:0] mem_req_addr;
   logic [NB-1:0]   mem_req_wstrb;
   logic [XLEN-1:0] mem_req_wdata;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_rdata;

   modport master (
      output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wstrb, mem_req_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wstrb, mem_req_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: stalls the core while one aligned access runs on the memory bus.
// Define LSU_TIMEOUT_EN to abandon a response wait after TIMEOUT cycles.
`timescale 1ns/1ps
module lsu_bus_ctrl #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned NB      = XLEN / 8,
   parameter int unsigned OFS     = $clog2(NB),
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                acs_en,
   input  logic                acs_wr,
   input  logic [NB-1:0]       acs_bytes,
   input  logic [XLEN-1:0]     acs_addr,
   input  logic [XLEN-1:0]     acs_wdata,
   output logic [XLEN-1:0]     acs_rdata,
   output logic                stall,
   output logic                misalign,
   output logic                bus_timeout,
   lsu_bus_ctrl_if.master      mem
);

   localparam int unsigned SW = OFS + 1;

   if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
      $error("lsu_bus_ctrl: XLEN must be 32 or 64");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("lsu_bus_ctrl: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

   state_e          state_q;
   logic            valid_q;
   logic            wr_q;
   logic [XLEN-1:0] addr_q;
   logic [NB-1:0]   strb_q;
   logic [XLEN-1:0] wdata_q;
   logic [OFS-1:0]  ofs_q;
   logic [NB-1:0]   bytes_q;
   logic [XLEN-1:0] rdata_q;
   logic            misalign_q;

   logic [SW-1:0]   size;
   logic [SW-1:0]   size_m1;
   logic [OFS-1:0]  ofs;
   logic            misaligned;
   logic [XLEN-1:0] addr_d;
   logic [NB-1:0]   strb_d;
   logic [XLEN-1:0] wdata_d;
   logic [XLEN-1:0] lane_mask;
   logic [XLEN-1:0] rdata_d;

   always_comb begin
      size = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         size = size + SW'(acs_bytes[i]);
      end
      size_m1    = size - SW'(1);
      ofs        = acs_addr[OFS-1:0];
      misaligned = |(ofs & size_m1[OFS-1:0]);
      addr_d     = acs_addr;
      addr_d[OFS-1:0] = '0;
      strb_d     = acs_bytes << ofs;
      wdata_d    = acs_wdata << {ofs, 3'b000};
   end

   // Load data: move the addressed lanes down to bit 0 and keep only the accessed bytes.
   always_comb begin
      lane_mask = '0;
      for (int unsigned b = 0; b < NB; b++) begin
         lane_mask[b*8 +: 8] = {8{bytes_q[b]}};
      end
      rdata_d = wr_q ? '0 : ((mem.mem_rsp_rdata >> {ofs_q, 3'b000}) & lane_mask);
   end

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CW-1:0] cnt_q;
   logic          timeout_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         strb_q     <= '0;
         wdata_q    <= '0;
         ofs_q      <= '0;
         bytes_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (acs_en) begin
                  if (misaligned) begin
                     misalign_q <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     wr_q    <= acs_wr;
                     addr_q  <= addr_d;
                     strb_q  <= strb_d;
                     wdata_q <= wdata_d;
                     ofs_q   <= ofs;
                     bytes_q <= acs_bytes;
                     valid_q <= 1'b1;
                     state_q <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem.mem_req_ready) begin
                  valid_q <= 1'b0;
                  state_q <= WAIT;
`ifdef LSU_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            WAIT: begin
               if (mem.mem_rsp_valid) begin
                  rdata_q <= rdata_d;
                  state_q <= DONE;
               end
`ifdef LSU_TIMEOUT_EN
               else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  rdata_q   <= '0;
                  timeout_q <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
`endif
            end
            DONE: begin
               misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
               timeout_q  <= 1'b0;
`endif
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall     = acs_en & (state_q != DONE);
   assign misalign  = misalign_q;
   assign acs_rdata = rdata_q;
`ifdef LSU_TIMEOUT_EN
   assign bus_timeout = timeout_q;
`else
   assign bus_timeout = 1'b0;
`endif

   assign mem.mem_req_valid = valid_q;
   assign mem.mem_req_wr    = wr_q;
   assign mem.mem_req_addr  = addr_q;
   assign mem.mem_req_wstrb = strb_q;
   assign mem.mem_req_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: directed accesses push expected bus requests and completions.
`timescale 1ns/1ps
module tb_lsu_bus_ctrl;
   localparam int unsigned XLEN = 64;
   localparam int unsigned NB   = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            acs_en = 1'b0;
   logic            acs_wr = 1'b0;
   logic [NB-1:0]   acs_bytes = '0;
   logic [XLEN-1:0] acs_addr = '0;
   logic [XLEN-1:0] acs_wdata = '0;
   logic [XLEN-1:0] acs_rdata;
   logic            stall;
   logic            misalign;
   logic            bus_timeout;

   lsu_bus_ctrl_if #(.XLEN(XLEN), .NB(NB)) bus ();

   lsu_bus_ctrl #(.XLEN(XLEN), .TIMEOUT(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .acs_en      (acs_en),
      .acs_wr      (acs_wr),
      .acs_bytes   (acs_bytes),
      .acs_addr    (acs_addr),
      .acs_wdata   (acs_wdata),
      .acs_rdata   (acs_rdata),
      .stall       (stall),
      .misalign    (misalign),
      .bus_timeout (bus_timeout),
      .mem         (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            wr;
      logic [XLEN-1:0] addr;
      logic [NB-1:0]   strb;
      logic [XLEN-1:0] wdata;
   } req_t;

   typedef struct packed {
      logic [XLEN-1:0] rdata;
      logic            mis;
      logic            tmo;
      logic [7:0]      stalls;
   } cmp_t;

   req_t req_q[$];
   cmp_t cmp_q[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares bus requests and completions against the queues.
   initial begin
      logic [7:0] stall_cnt;
      req_t r;
      cmp_t c;
      stall_cnt = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_cnt = '0;
         end else begin
            if (bus.mem_req_valid) begin
               if (req_q.size() == 0) begin
                  chk("unexpected_req", 64'(bus.mem_req_valid), 64'd0);
               end else begin
                  r = req_q[0];
                  chk("req_wr",    64'(bus.mem_req_wr), 64'(r.wr));
                  chk("req_addr",  bus.mem_req_addr, r.addr);
                  chk("req_wstrb", 64'(bus.mem_req_wstrb), 64'(r.strb));
                  chk("req_wdata", bus.mem_req_wdata, r.wdata);
                  if (bus.mem_req_ready) void'(req_q.pop_front());
               end
            end
            if (acs_en && stall) begin
               stall_cnt = stall_cnt + 8'd1;
            end else if (acs_en) begin
               if (cmp_q.size() == 0) begin
                  chk("unexpected_done", 64'(acs_en && !stall), 64'd0);
               end else begin
                  c = cmp_q.pop_front();
                  chk("done_rdata",    acs_rdata, c.rdata);
                  chk("done_misalign", 64'(misalign), 64'(c.mis));
                  chk("done_timeout",  64'(bus_timeout), 64'(c.tmo));
                  chk("stall_cycles",  64'(stall_cnt), 64'(c.stalls));
               end
               stall_cnt = '0;
            end else begin
               chk("idle_misalign", 64'(misalign), 64'd0);
               chk("idle_timeout",  64'(bus_timeout), 64'd0);
            end
         end
      end
   end

   // Starts at #1 after a posedge with the DUT in IDLE; leaves acs_en asserted.
   task automatic access(
      input logic wr, input logic [NB-1:0] bytes, input logic [XLEN-1:0] addr,
      input logic [XLEN-1:0] wdata, input int rdy_wait, input logic give_rsp,
      input logic [XLEN-1:0] rsp, input logic push_cmp, input logic mis,
      input logic [XLEN-1:0] exp_addr, input logic [NB-1:0] exp_strb,
      input logic [XLEN-1:0] exp_wdata, input logic [XLEN-1:0] exp_rdata,
      input logic [7:0] exp_stalls);
      if (!mis) req_q.push_back('{wr: wr, addr: exp_addr, strb: exp_strb, wdata: exp_wdata});
      if (push_cmp) cmp_q.push_back('{rdata: exp_rdata, mis: mis, tmo: 1'b0, stalls: exp_stalls});
      acs_en = 1'b1; acs_wr = wr; acs_bytes = bytes; acs_addr = addr; acs_wdata = wdata;
      if (mis) begin
         @(posedge clk); #1;
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
         bus.mem_req_ready = 1'b0;
         repeat (rdy_wait) begin @(posedge clk); #1; end
         bus.mem_req_ready = 1'b1;
         @(posedge clk); #1;
         bus.mem_req_ready = 1'b0;
         if (give_rsp) begin
            bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = rsp;
            @(posedge clk); #1;
            bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 64'h5555_5555_5555_5555;
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      #2;
      chk("rst_stall",    64'(stall), 64'd0);
      chk("rst_valid",    64'(bus.mem_req_valid), 64'd0);
      chk("rst_rdata",    acs_rdata, 64'd0);
      chk("rst_misalign", 64'(misalign), 64'd0);
      chk("rst_timeout",  64'(bus_timeout), 64'd0);
      chk("rst_addr",     bus.mem_req_addr, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // wr bytes addr wdata rdy rsp? rsp push mis exp_addr exp_strb exp_wdata exp_rdata stalls
      access(0, 8'hFF, 64'h1000, 64'h0, 0, 1, 64'h1122334455667788, 1, 0,
             64'h1000, 8'hFF, 64'h0, 64'h1122334455667788, 8'd3);
      access(1, 8'h01, 64'h2005, 64'hAB, 0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 1, 0,
             64'h2000, 8'h20, 64'h0000AB0000000000, 64'h0, 8'd3);
      access(0, 8'h03, 64'h3006, 64'h0, 0, 1, 64'hBEEF000000000000, 1, 0,
             64'h3000, 8'hC0, 64'h0, 64'hBEEF, 8'd3);
      access(0, 8'h03, 64'h3005, 64'h0, 0, 0, 64'h0, 1, 1,
             64'h0, 8'h00, 64'h0, 64'hBEEF, 8'd1);
      access(1, 8'h0F, 64'h4004, 64'h12345678, 4, 1, 64'h0, 1, 0,
             64'h4000, 8'hF0, 64'h1234567800000000, 64'h0, 8'd7);
      access(0, 8'h0F, 64'h5004, 64'h0, 0, 1, 64'hCAFEBABE11223344, 1, 0,
             64'h5000, 8'hF0, 64'h0, 64'hCAFEBABE, 8'd3);
      access(0, 8'h01, 64'h6003, 64'h0, 1, 1, 64'hFFFFFFFF5AFFFFFF, 1, 0,
             64'h6000, 8'h08, 64'h0, 64'h5A, 8'd4);
      access(0, 8'hFF, 64'h7004, 64'h0, 0, 0, 64'h0, 1, 1,
             64'h0, 8'h00, 64'h0, 64'h5A, 8'd1);
      acs_en = 1'b0;

      // Response while idle must not disturb held load data.
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = '1;
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      chk("idle_rsp_ignored", acs_rdata, 64'h5A);

      // Reset during WAIT.
      access(0, 8'hFF, 64'h8000, 64'h0, 0, 0, 64'h0, 0, 0,
             64'h8000, 8'hFF, 64'h0, 64'h0, 8'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(bus.mem_req_valid), 64'd0);
      chk("midrst_rdata", acs_rdata, 64'd0);
      chk("midrst_stall_held", 64'(stall), 64'd1);
      acs_en = 1'b0;
      #1;
      chk("midrst_stall_drop", 64'(stall), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 64'h0123456789ABCDEF;
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      @(posedge clk); #1;
      chk("late_rsp_rdata", acs_rdata, 64'd0);
      chk("late_rsp_valid", 64'(bus.mem_req_valid), 64'd0);

`ifdef LSU_TIMEOUT_EN
      cmp_q.push_back('{rdata: 64'h0, mis: 1'b0, tmo: 1'b1, stalls: 8'd10});
      access(0, 8'hFF, 64'h9000, 64'h0, 0, 0, 64'h0, 0, 0,
             64'h9000, 8'hFF, 64'h0, 64'h0, 8'd0);
      repeat (8) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      acs_en = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = '1;
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      chk("tmo_late_rsp", acs_rdata, 64'd0);
`else
      access(0, 8'hFF, 64'h9000, 64'h0, 0, 0, 64'h0, 0, 0,
             64'h9000, 8'hFF, 64'h0, 64'h0, 8'd0);
      begin
         int hi;
         hi = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall) hi++;
         end
         chk("no_tmo_stall_held", 64'(hi), 64'd100);
      end
      chk("no_tmo_flag", 64'(bus_timeout), 64'd0);
      rst_n = 1'b0;
      acs_en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("req_queue_empty", 64'(req_q.size()), 64'd0);
      chk("cmp_queue_empty", 64'(cmp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
